md_unit: RTL and testbench



---
 rtl/md_pkg.sv | 30 +++
 rtl/md_if.sv | 28 ++
 rtl/md_iter_core.sv | 115 +++++++++++
 rtl/md_unit.sv | 89 ++++++++
 tb/tb_md_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// codes, FSM states and the default datapath width.
package md_pkg;

    localparam int MD_WIDTH = 32;

    // Operation select driven by the decoder alongside start.
    typedef enum logic [2:0] {
        md_none    = 3'b000,
        md_mult    = 3'b001,
        md_multu   = 3'b010,
        md_div     = 3'b011,
        md_divu    = 3'b100,
        md_mthi    = 3'b101,
        md_mtlo    = 3'b110,
        md_none_hi = 3'b111
    } md_code_e;

    typedef enum logic [1:0] {
        st_idle,
        st_run,
        st_fix
    } md_state_e;

    // True for the codes that occupy the unit for a full iteration sequence.
    function automatic logic is_muldiv(input md_code_e c);
        return (c == md_mult) || (c == md_multu) || (c == md_div) || (c == md_divu);
    endfunction

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_if
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             start;
    md_code_e         MDCode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    // EX-stage side: issues requests, observes status and HI/LO.
    modport master (
        output start, MDCode, A, B, flush,
        input  busy, done, HI, LO
    );

    // Unit side.
    modport slave (
        input  start, MDCode, A, B, flush,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/md_iter_core.sv
// Iteration datapath: operand magnitudes, sign flags, the 64-bit
// accumulator, the step counter, and the sign-corrected result view.
module md_iter_core
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = WIDTH,
    parameter int CNT_W = $clog2(ITER)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  md_code_e         op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    op_div;
    logic                    op_signed;
    logic                    neg_a;
    logic                    neg_b;
    logic [WIDTH-1:0]        mag_a;
    logic [WIDTH-1:0]        mag_b;

    logic                    is_div;
    logic                    sign_a;
    logic                    sign_b;
    logic                    dz;
    logic [2*WIDTH-1:0]      acc;
    logic [WIDTH-1:0]        opnd;

    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      mul_next;
    logic [WIDTH:0]          div_up;
    logic [WIDTH-1:0]        div_diff;
    logic [2*WIDTH-1:0]      div_next;
    logic [2*WIDTH-1:0]      prod;
    logic [WIDTH-1:0]        quo;
    logic [WIDTH-1:0]        rem;

    function automatic logic [WIDTH-1:0] cneg(input logic c, input logic [WIDTH-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic c, input logic [2*WIDTH-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    assign a_s       = a;
    assign b_s       = b;
    assign op_div    = (op == md_div) || (op == md_divu);
    assign op_signed = (op == md_mult) || (op == md_div);
    assign neg_a     = op_signed && (a_s < 0);
    assign neg_b     = op_signed && (b_s < 0);
    assign mag_a     = cneg(neg_a, a);
    assign mag_b     = cneg(neg_b, b);

    // Multiply: {HI,LO} holds {partial, multiplier}; add multiplicand when
    // the multiplier LSB is set, then shift right with the carry.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Restoring divide: shift {rem,quo} left, subtract divisor when it fits.
    // The partial remainder can briefly need WIDTH+1 bits, but the difference
    // is always below the divisor so its low WIDTH bits are exact.
    assign div_up   = acc[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_up[WIDTH-1:0] - opnd;
    assign div_next = (div_up >= {1'b0, opnd}) ? {div_diff, acc[WIDTH-2:0], 1'b1}
                                               : {div_up[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    // Control state: counter and operation/sign flags captured at issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
        end else if (load) begin
            count  <= '0;
            is_div <= op_div;
            sign_a <= neg_a;
            sign_b <= neg_b;
            dz     <= op_div && (b == '0);
        end else if (step) begin
            count  <= count + 1'b1;
        end
    end

    // Datapath: accumulator seeded at issue, advanced one step per RUN cycle.
    always_ff @(posedge clk) begin
        if (load) begin
            acc  <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
            opnd <= op_div ? mag_b : mag_a;
        end else if (step) begin
            acc  <= is_div ? div_next : mul_next;
        end
    end

    assign prod = cneg2(sign_a ^ sign_b, acc);
    assign quo  = cneg(sign_a ^ sign_b, acc[WIDTH-1:0]);
    // With a zero divisor every step subtracts nothing, so the remainder ends
    // as the dividend magnitude and re-signing it reproduces A exactly.
    assign rem  = cneg(sign_a, acc[2*WIDTH-1:WIDTH]);

    assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    assign res_lo = is_div ? (dz ? {WIDTH{1'b1}} : quo) : prod[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit beside the EX-stage ALU: owns HI/LO, sequences the
// iteration core, and handles flush and reset.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    md_if.slave  bus
);

    localparam int CNT_W = $clog2(ITER);

    md_state_e        state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             accept;
    logic             load;
    logic             step;
    logic             last_iter;

    // A request only counts when idle and not being flushed in the same cycle.
    assign accept    = (state == st_idle) && bus.start && !bus.flush;
    assign load      = accept && is_muldiv(bus.MDCode);
    assign step      = (state == st_run);
    assign last_iter = (count == CNT_W'(ITER - 1));
    assign bus.busy  = (state != st_idle);

    md_iter_core #(
        .WIDTH (WIDTH),
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .op     (bus.MDCode),
        .a      (bus.A),
        .b      (bus.B),
        .count  (count),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // FSM with registered done and the architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= st_idle;
            bus.done <= 1'b0;
            bus.HI <= '0;
            bus.LO <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                st_idle: begin
                    if (accept) begin
                        case (bus.MDCode)
                            md_mult, md_multu, md_div, md_divu: state <= st_run;
                            md_mthi: bus.HI <= bus.A;
                            md_mtlo: bus.LO <= bus.A;
                            default: ;
                        endcase
                    end
                end
                st_run: begin
                    if (bus.flush) begin
                        state <= st_idle;
                    end else if (last_iter) begin
                        state <= st_fix;
                    end
                end
                st_fix: begin
                    state <= st_idle;
                    if (!bus.flush) begin
                        bus.HI   <= res_hi;
                        bus.LO   <= res_lo;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: hand-computed HI/LO results, latency, done
// pulse, flush, back-to-back issue and asynchronous reset.
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    md_if #(.WIDTH(32)) bus ();

    md_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Presents a request for one edge; returns at the negedge after that edge.
    task automatic issue(input md_code_e code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.MDCode = code;
        bus.A      = a;
        bus.B      = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.MDCode = md_none;
    endtask

    // Counts busy cycles (starting from 'already') until busy drops, bounded.
    task automatic wait_done(input string tag, input int already);
        int n;
        n = already;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, n, 33);
        chk({tag, "_done"}, bus.done, 1);
    endtask

    task automatic run_op(input string tag, input md_code_e code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
        issue(code, a, b);
        wait_done(tag, 0);
        chk({tag, "_hi"}, bus.HI, hi);
        chk({tag, "_lo"}, bus.LO, lo);
        @(negedge clk);
        chk({tag, "_done_drop"}, bus.done, 0);
    endtask

    initial begin
        logic seen_done;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.MDCode = md_none;
        bus.A      = '0;
        bus.B      = '0;
        bus.flush  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_hi", bus.HI, 0);
        chk("rst_lo", bus.LO, 0);
        rst_n = 1'b1;

        run_op("mult_neg", md_mult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("divu", md_divu, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_neg", md_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_zero", md_div, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
        run_op("div_ovf", md_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Moves to HI then LO on consecutive cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.MDCode = md_mthi; bus.A = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mthi_hi", bus.HI, 32'hDEAD_BEEF);
        chk("mthi_busy", bus.busy, 0);
        bus.MDCode = md_mtlo; bus.A = 32'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.MDCode = md_none;
        chk("mtlo_lo", bus.LO, 32'd1);
        chk("mtlo_hi", bus.HI, 32'hDEAD_BEEF);
        chk("mtlo_busy", bus.busy, 0);

        // Flush of an in-flight mult around cycle 10.
        issue(md_mult, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        chk("flush_busy_before", bus.busy, 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        chk("flush_no_done", seen_done, 0);
        chk("flush_hi", bus.HI, 32'hDEAD_BEEF);
        chk("flush_lo", bus.LO, 32'd1);

        // Flush together with an idle-cycle mthi drops the write.
        bus.start = 1'b1; bus.flush = 1'b1; bus.MDCode = md_mthi; bus.A = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0; bus.MDCode = md_none;
        chk("flush_mthi_hi", bus.HI, 32'hDEAD_BEEF);
        chk("flush_mthi_busy", bus.busy, 0);

        // multu with a stray divu request while busy.
        issue(md_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.MDCode = md_divu; bus.A = 32'd9; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.MDCode = md_none;
        wait_done("multu", 4);
        chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
        chk("multu_lo", bus.LO, 32'd1);

        // Back-to-back divu issued in the done cycle.
        bus.start = 1'b1; bus.MDCode = md_divu; bus.A = 32'd1000; bus.B = 32'd10;
        @(negedge clk);
        bus.start = 1'b0; bus.MDCode = md_none;
        chk("b2b_done_drop", bus.done, 0);
        wait_done("b2b_divu", 0);
        chk("b2b_hi", bus.HI, 32'd0);
        chk("b2b_lo", bus.LO, 32'd100);

        // Asynchronous reset in the middle of a mult.
        issue(md_mult, 32'd6, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_hi", bus.HI, 0);
        chk("arst_lo", bus.LO, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1; bus.MDCode = md_mult; bus.A = 32'd6; bus.B = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.MDCode = md_none;
        wait_done("post_rst", 0);
        chk("post_rst_hi", bus.HI, 32'd0);
        chk("post_rst_lo", bus.LO, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
